// File: rtl/t07_pkg.sv
// Shared team-07 decode constants: RV32I opcodes, shift funct3 codes and
// the immediate-format selector used between the format decoder and the datapath.
package t07_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_SHAMT,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U
   } imm_fmt_e;

endpackage

// File: rtl/t07_imm_fmt_decode.sv
// Combinational opcode/funct3 to immediate-format classifier.
module t07_imm_fmt_decode
   import t07_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   output imm_fmt_e   fmt
);

   // func3 is only examined under OP-IMM so an undefined func3 on any
   // other opcode cannot reach the format select.
   always_comb begin
      fmt = IMM_NONE;
      case (opcode)
         OPC_LOAD,
         OPC_JALR:   fmt = IMM_I;
         OPC_OPIMM: begin
            if (func3 == F3_SLL || func3 == F3_SR)
               fmt = IMM_SHAMT;
            else
               fmt = IMM_I;
         end
         OPC_STORE:  fmt = IMM_S;
         OPC_BRANCH: fmt = IMM_B;
         OPC_JAL:    fmt = IMM_J;
         OPC_LUI,
         OPC_AUIPC:  fmt = IMM_U;
         default:    fmt = IMM_NONE;
      endcase
   end

endmodule

// File: rtl/t07_imm_gen.sv
// RV32I immediate generator: classifies the instruction format, assembles the
// 32-bit immediate and registers it for one cycle of latency.
module t07_imm_gen
   import t07_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  func3,
   input  logic [31:0] instruction,
   output logic [31:0] immediate
);

   imm_fmt_e    fmt;
   logic [31:0] imm_next;

   t07_imm_fmt_decode u_fmt_decode (
      .opcode (instruction[6:0]),
      .func3  (func3),
      .fmt    (fmt)
   );

   // U-type stays right-aligned; the consumer applies the <<12 itself.
   always_comb begin
      imm_next = 32'h0;
      case (fmt)
         IMM_I:     imm_next = {{20{instruction[31]}}, instruction[31:20]};
         IMM_SHAMT: imm_next = {27'h0, instruction[24:20]};
         IMM_S:     imm_next = {{20{instruction[31]}}, instruction[31:25],
                                instruction[11:7]};
         IMM_B:     imm_next = {{19{instruction[31]}}, instruction[31],
                                instruction[7], instruction[30:25],
                                instruction[11:8], 1'b0};
         IMM_J:     imm_next = {{11{instruction[31]}}, instruction[31],
                                instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0};
         IMM_U:     imm_next = {12'h0, instruction[31:12]};
         default:   imm_next = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         immediate <= 32'h0;
      else
         immediate <= imm_next;
   end

endmodule

// File: tb/tb_t07_imm_gen.sv
// Scoreboard bench for t07_imm_gen: each driven cycle queues its expected
// immediate, and a monitor compares one entry per clock after the capture edge.
module tb_t07_imm_gen;

   logic        clk;
   logic        rst;
   logic [2:0]  func3;
   logic [31:0] instruction;
   logic [31:0] immediate;

   int assert_count;
   int fail_count;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   t07_imm_gen dut (
      .clk         (clk),
      .rst         (rst),
      .func3       (func3),
      .instruction (instruction),
      .immediate   (immediate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Inputs change on the falling edge; the expected value is queued at the
   // same moment and falls due right after the next rising edge.
   task automatic applyStimulus(input string tag, input logic r,
                                input logic [31:0] instr, input logic [2:0] f3,
                                input logic [31:0] expected);
      @(negedge clk);
      rst         = r;
      instruction = instr;
      func3       = f3;
      tag_q.push_back(tag);
      exp_q.push_back(expected);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         string       t;
         logic [31:0] e;
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         checkOutput(t, immediate, e);
      end
   end

   initial begin
      int budget;
      assert_count = 0;
      fail_count   = 0;
      rst          = 1'b1;
      instruction  = 32'h0;
      func3        = 3'b000;

      applyStimulus("reset0", 1'b1, 32'h0464_7513, 3'b111, 32'h0);
      applyStimulus("reset1", 1'b1, 32'h0C80_0183, 3'b000, 32'h0);
      applyStimulus("lb_200", 1'b0, 32'h0C80_0183, 3'b000, 32'd200);

      applyStimulus("jalr_pos", 1'b0, 32'h0042_80E7, 3'b000, 32'd4);
      applyStimulus("jalr_neg", 1'b0, 32'hFFC2_80E7, 3'b000, 32'hFFFF_FFFC);
      applyStimulus("addi_m12", 1'b0, 32'hFF43_0293, 3'b000, 32'hFFFF_FFF4);
      applyStimulus("andi_m70", 1'b0, 32'hFBA4_7513, 3'b111, 32'hFFFF_FFBA);
      applyStimulus("andi_70",  1'b0, 32'h0464_7513, 3'b111, 32'd70);
      applyStimulus("imm_fff",  1'b0, 32'hFFF0_0013, 3'b000, 32'hFFFF_FFFF);
      applyStimulus("imm_800",  1'b0, 32'h8000_0013, 3'b000, 32'hFFFF_F800);

      applyStimulus("slli_3",   1'b0, 32'h0031_9113, 3'b001, 32'd3);
      applyStimulus("srli_3",   1'b0, 32'h0031_9113, 3'b101, 32'd3);
      applyStimulus("srai_4",   1'b0, 32'h4044_9393, 3'b101, 32'd4);
      applyStimulus("shf_8",    1'b0, 32'h0C80_0193, 3'b001, 32'd8);
      applyStimulus("addi_200", 1'b0, 32'h0C80_0193, 3'b000, 32'd200);
      applyStimulus("shamt_31", 1'b0, 32'hFFF0_1013, 3'b001, 32'd31);

      applyStimulus("sb_150",   1'b0, 32'h0830_0B23, 3'b000, 32'd150);
      applyStimulus("beq_100",  1'b0, 32'h0631_0263, 3'b000, 32'd100);
      applyStimulus("jal_50",   1'b0, 32'h0320_016F, 3'b000, 32'd50);
      applyStimulus("b_neg4",   1'b0, 32'hFE00_0EE3, 3'b000, 32'hFFFF_FFFC);
      applyStimulus("j_neg",    1'b0, 32'hFFFF_F06F, 3'b000, 32'hFFFF_FFFE);

      applyStimulus("lui_25",   1'b0, 32'h0001_9137, 3'b000, 32'd25);
      applyStimulus("auipc",    1'b0, 32'hFFFF_F117, 3'b000, 32'h000F_FFFF);
      applyStimulus("rtype",    1'b0, 32'h0000_0033, 3'b001, 32'h0);
      applyStimulus("lui_f3x",  1'b0, 32'h0001_9137, 3'bxxx, 32'd25);
      applyStimulus("store_f3", 1'b0, 32'h0830_0B23, 3'b101, 32'd150);

      applyStimulus("pipe0",    1'b0, 32'h0042_80E7, 3'b000, 32'd4);
      applyStimulus("pipe1",    1'b0, 32'h0631_0263, 3'b000, 32'd100);
      applyStimulus("pipe2",    1'b1, 32'h0320_016F, 3'b000, 32'h0);
      applyStimulus("pipe3",    1'b0, 32'h0001_9137, 3'b000, 32'd25);
      applyStimulus("pipe4",    1'b0, 32'h0830_0B23, 3'b000, 32'd150);
      applyStimulus("pipe5",    1'b0, 32'hFF43_0293, 3'b000, 32'hFFFF_FFF4);

      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         assert_count++;
         fail_count++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
